// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 write engine.
// FSM states, init command ROM and the clear/home command codes.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  localparam int INIT_LEN = 4;
  localparam int K_W      = $clog2(INIT_LEN);

  localparam logic [7:0] INIT_FUNC = 8'h38;
  localparam logic [7:0] INIT_DISP = 8'h0C;
  localparam logic [7:0] INIT_CLR  = 8'h01;
  localparam logic [7:0] INIT_MODE = 8'h06;

  localparam logic [7:0] CMD_CLR      = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_rom(
    input logic [K_W-1:0] k
  );
    case (k)
      K_W'(0): return INIT_FUNC;
      K_W'(1): return INIT_DISP;
      K_W'(2): return INIT_CLR;
      default: return INIT_MODE;
    endcase
  endfunction

  // Clear and return-home need the long execution wait.
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] d
  );
    return !rs && (d == CMD_CLR ||
                   d == CMD_HOME ||
                   d == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter shared by all engine phases.
// Ports: i_load/i_val reload the count, o_done is high while count is 0.
module lcd_delay_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl: hardware-timed HD44780 write engine with power-up init.
// Ports: i_valid/o_ready/i_rs/i_data request side, o_lcd_* pins, o_init_done.
module lcd_write_ctrl
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 750000,
  parameter int SETUP_CYC    = 2,
  parameter int EN_HIGH_CYC  = 12,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on,
  output logic       o_init_done
);

  localparam int MAXC = imax(imax(imax(PWRUP_CYC, SETUP_CYC),
                                  imax(EN_HIGH_CYC, HOLD_CYC)),
                             imax(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SU_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EH_LD = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] HO_LD = CW'(HOLD_CYC - 1);

  // PWRUP and WAIT each give their last cycle to the following
  // INIT_LOAD/IDLE cycle, so the next load edge lands exactly
  // N cycles after the phase starts.
  localparam logic [CW-1:0] PW_RST =
    (PWRUP_CYC > 1) ? CW'(PWRUP_CYC - 2) : '0;
  localparam lcd_state_e RST_ST =
    (PWRUP_CYC > 1) ? ST_PWRUP : ST_INIT_LOAD;

  if (PWRUP_CYC < 1 || SETUP_CYC < 1 || EN_HIGH_CYC < 1 ||
      HOLD_CYC < 1 || CMD_WAIT_CYC < 1 ||
      CLR_WAIT_CYC < 1) begin : g_bad_param
    $error("lcd_write_ctrl: cycle parameters must be >= 1");
  end

  lcd_state_e     r_state;
  lcd_state_e     w_state_nxt;
  logic           w_ld;
  logic [CW-1:0]  w_ld_val;
  logic           w_done;
  logic           w_acc;
  logic           w_fin;
  logic           w_last;
  logic [CW-1:0]  w_wait_len;

  logic [K_W-1:0] r_k;
  logic           r_ready;
  logic           r_en;
  logic           r_rs;
  logic           r_on;
  logic           r_init_done;
  logic [7:0]     r_data;

  logic [K_W-1:0] w_k_nxt;
  logic           w_ready_nxt;
  logic           w_en_nxt;
  logic           w_rs_nxt;
  logic           w_done_nxt;
  logic [7:0]     w_data_nxt;

  lcd_delay_timer #(
    .W       (CW),
    .RST_VAL (PW_RST)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_ld),
    .i_val   (w_ld_val),
    .o_done  (w_done)
  );

  assign w_wait_len = is_long_cmd(r_rs, r_data) ?
                      CW'(CLR_WAIT_CYC) : CW'(CMD_WAIT_CYC);
  assign w_last = (r_k == K_W'(INIT_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RST_ST;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_val    = '0;
    w_acc       = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      ST_PWRUP: begin
        if (w_done) w_state_nxt = ST_INIT_LOAD;
      end
      ST_INIT_LOAD: w_acc = 1'b1;
      ST_IDLE:      w_acc = i_valid;
      ST_SETUP: begin
        if (w_done) begin
          w_state_nxt = ST_EN_HI;
          w_ld        = 1'b1;
          w_ld_val    = EH_LD;
        end
      end
      ST_EN_HI: begin
        if (w_done) begin
          w_state_nxt = ST_HOLD;
          w_ld        = 1'b1;
          w_ld_val    = HO_LD;
        end
      end
      ST_HOLD: begin
        if (w_done) begin
          if (w_wait_len > CW'(1)) begin
            w_state_nxt = ST_WAIT;
            w_ld        = 1'b1;
            w_ld_val    = w_wait_len - CW'(2);
          end else begin
            w_fin = 1'b1;
          end
        end
      end
      ST_WAIT: w_fin = w_done;
      default: w_state_nxt = RST_ST;
    endcase
    if (w_acc) begin
      w_state_nxt = ST_SETUP;
      w_ld        = 1'b1;
      w_ld_val    = SU_LD;
    end
    if (w_fin) begin
      w_state_nxt = (r_init_done || w_last) ?
                    ST_IDLE : ST_INIT_LOAD;
    end
  end

  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_en_nxt    = (w_state_nxt == ST_EN_HI);
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    w_k_nxt     = r_k;
    w_done_nxt  = r_init_done | (w_fin & w_last);
    if (r_state == ST_INIT_LOAD) begin
      w_rs_nxt   = 1'b0;
      w_data_nxt = init_rom(r_k);
    end else if (w_acc) begin
      w_rs_nxt   = i_rs;
      w_data_nxt = i_data;
    end
    if (w_fin && !r_init_done && !w_last) begin
      w_k_nxt = r_k + K_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k         <= '0;
      r_ready     <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= '0;
      r_on        <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_k         <= w_k_nxt;
      r_ready     <= w_ready_nxt;
      r_en        <= w_en_nxt;
      r_rs        <= w_rs_nxt;
      r_data      <= w_data_nxt;
      r_on        <= 1'b1;
      r_init_done <= w_done_nxt;
    end
  end

  assign o_ready     = r_ready;
  assign o_lcd_en    = r_en;
  assign o_lcd_rs    = r_rs;
  assign o_lcd_data  = r_data;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_on    = r_on;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// tb_lcd_write_ctrl: randomized self-checking bench for lcd_write_ctrl.
// Expected timing is derived from phase lengths with plain arithmetic.
module tb_lcd_write_ctrl;

  localparam int PW   = 10;
  localparam int SU   = 2;
  localparam int EH   = 4;
  localparam int HO   = 2;
  localparam int CMDW = 8;
  localparam int CLRW = 20;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       rs    = 1'b0;
  logic [7:0] data  = '0;
  logic       ready, lrs, lrw, len, lon, idone;
  logic [7:0] ldata;

  int cyc    = 0;
  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_write_ctrl #(
    .PWRUP_CYC    (PW),
    .SETUP_CYC    (SU),
    .EN_HIGH_CYC  (EH),
    .HOLD_CYC     (HO),
    .CMD_WAIT_CYC (CMDW),
    .CLR_WAIT_CYC (CLRW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_rs        (rs),
    .i_data      (data),
    .o_lcd_data  (ldata),
    .o_lcd_rs    (lrs),
    .o_lcd_rw    (lrw),
    .o_lcd_en    (len),
    .o_lcd_on    (lon),
    .o_init_done (idone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input logic r,
                                 input logic [7:0] d);
    if (!r && d >= 8'h01 && d <= 8'h03) return CLRW;
    return CMDW;
  endfunction

  function automatic int busy_of(input logic r,
                                 input logic [7:0] d);
    return SU + EH + HO + wait_of(r, d);
  endfunction

  // Called at the negedge following a load edge ld.
  task automatic mon_seg(input int ld, input logic [7:0] d,
                         input logic r, input bit exp_rdy,
                         input bit noise, input string tag,
                         output int rise);
    int   fall, pulses, bad, rdy, b;
    logic pen;
    rise = -1; fall = -1; pulses = 0; bad = 0; rdy = -1;
    pen = len;
    b = busy_of(r, d);
    for (int n = ld + 1; n < ld + b; n++) begin
      @(negedge clk);
      if (noise) begin
        data = 8'($urandom);
        rs   = 1'($urandom);
      end
      if (len && !pen) begin
        pulses++;
        if (rise < 0) rise = cyc;
      end
      if (!len && pen && fall < 0) fall = cyc;
      pen = len;
      if (ldata !== d || lrs !== r || lrw !== 1'b0) bad++;
      if (ready && rdy < 0) rdy = cyc;
    end
    chk({tag, ".rise"}, 32'(rise - ld), 32'(SU));
    chk({tag, ".width"}, 32'(fall - rise), 32'(EH));
    chk({tag, ".pulses"}, 32'(pulses), 32'd1);
    chk({tag, ".stable"}, 32'(bad), 32'd0);
    chk({tag, ".ready"}, 32'(rdy),
        exp_rdy ? 32'(ld + b - 1) : 32'hFFFF_FFFF);
  endtask

  task automatic start_write(input logic r, input logic [7:0] d,
                             input bit hold, output int ld);
    int k;
    k = 0;
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wr.ready_wait", 32'(ready), 32'd1);
    valid = 1'b1;
    rs    = r;
    data  = d;
    @(negedge clk);
    ld = cyc;
    if (!hold) valid = 1'b0;
  endtask

  // Entered at a negedge with reset asserted.
  task automatic run_init(input string tag);
    int t0, ld, rise;
    chk({tag, ".rst_out"},
        32'({len, lrs, lrw, lon, idone, ready, ldata}), 32'd0);
    t0 = cyc;
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, ".on"}, 32'({lon, ready, idone}), 32'b100);
    repeat (PW - 1) @(negedge clk);
    ld = t0 + PW;
    for (int k = 0; k < 4; k++) begin
      mon_seg(ld, init_seq[k], 1'b0, k == 3, 1'b0,
              $sformatf("%s.i%0d", tag, k), rise);
      if (k == 0) begin
        chk({tag, ".first_en"}, 32'(rise - t0), 32'(PW + SU));
        chk({tag, ".done0"}, 32'(idone), 32'd0);
      end
      if (k < 3) begin
        @(negedge clk);
        ld = ld + busy_of(1'b0, init_seq[k]);
      end
    end
    chk({tag, ".done"}, 32'(idone), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ld, ld2, r1, r2, k;
    logic [7:0] d;
    logic       r;

    repeat (3) @(negedge clk);
    run_init("s1");
    chk("rw_low", 32'(lrw), 32'd0);

    start_write(1'b1, 8'h41, 1'b0, ld);
    mon_seg(ld, 8'h41, 1'b1, 1'b1, 1'b0, "s2", r1);

    start_write(1'b0, 8'h01, 1'b0, ld);
    mon_seg(ld, 8'h01, 1'b0, 1'b1, 1'b0, "s3clr", r1);
    start_write(1'b1, 8'h01, 1'b0, ld);
    mon_seg(ld, 8'h01, 1'b1, 1'b1, 1'b0, "s3chr", r1);

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      r = 1'($urandom);
      if (i < 2) begin
        d = 8'(i + 2);
        r = 1'b0;
      end
      start_write(r, d, 1'b0, ld);
      mon_seg(ld, d, r, 1'b1, 1'b0,
              $sformatf("rnd%0d", i), r1);
    end

    d = 8'($urandom);
    r = 1'($urandom);
    start_write(r, d, 1'b1, ld);
    mon_seg(ld, d, r, 1'b1, 1'b1, "s4", r1);
    valid = 1'b0;
    @(negedge clk);
    chk("s4.no_extra", 32'({ready, len}), 32'b10);

    start_write(1'b1, 8'h48, 1'b1, ld);
    data = 8'h49;
    mon_seg(ld, 8'h48, 1'b1, 1'b1, 1'b0, "s6a", r1);
    @(negedge clk);
    ld2 = cyc;
    valid = 1'b0;
    chk("s6.accepted", 32'(ready), 32'd0);
    mon_seg(ld2, 8'h49, 1'b1, 1'b1, 1'b0, "s6b", r2);
    chk("s6.spacing", 32'(r2 - r1), 32'(SU + EH + HO + CMDW));

    start_write(1'b1, 8'h55, 1'b0, ld);
    k = 0;
    while (!len && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("s5.en_seen", 32'(len), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5.async", 32'({len, ready, idone, lon}), 32'd0);
    @(negedge clk);
    run_init("s5");
    start_write(1'b1, 8'h5A, 1'b0, ld);
    mon_seg(ld, 8'h5A, 1'b1, 1'b1, 1'b0, "s5post", r1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
